// File: rtl/neuron_pkg.sv
// Shared definitions for the layer sequencer and the serial neuron MAC it drives:
// default data widths, a width helper and the sequencer state encoding.
package neuron_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned W_W   = 8;
  localparam int unsigned B_W   = 16;
  localparam int unsigned OUT_W = 16;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_MAC = 3'd4,
    S_DONE     = 3'd5,
    S_DRAIN    = 3'd6
  } state_e;

endpackage

// File: rtl/neuron_layer_sched_if.sv
// Job/result handshake between the layer sequencer (master) and one serial neuron MAC (slave).
interface neuron_layer_sched_if #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned X_W        = neuron_pkg::X_W,
  parameter int unsigned W_W        = neuron_pkg::W_W,
  parameter int unsigned B_W        = neuron_pkg::B_W,
  parameter int unsigned OUT_W      = neuron_pkg::OUT_W
);

  logic                        in_valid;
  logic                        in_ready;
  logic [B_W-1:0]              bias;
  logic [NUM_INPUTS*X_W-1:0]   x_flat;
  logic [NUM_INPUTS*W_W-1:0]   w_flat;
  logic                        out_valid;
  logic [OUT_W-1:0]            out_data;

  modport master (
    output in_valid, bias, x_flat, w_flat,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, bias, x_flat, w_flat,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one serial neuron MAC across all neurons of a fully-connected layer,
// fetching bias/weights per neuron and collecting results into a packed output vector.
module neuron_layer_sched #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned X_W         = neuron_pkg::X_W,
  parameter int unsigned W_W         = neuron_pkg::W_W,
  parameter int unsigned B_W         = neuron_pkg::B_W,
  parameter int unsigned OUT_W       = neuron_pkg::OUT_W,
  parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? neuron_pkg::clog2(NUM_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_INPUTS*X_W-1:0]     x_flat,
  output logic                          wmem_rd,
  output logic [IDX_W-1:0]              wmem_addr,
  input  logic [NUM_INPUTS*W_W-1:0]     wmem_rdata_w,
  input  logic [B_W-1:0]                wmem_rdata_b,
  neuron_layer_sched_if.master          mac,
  output logic [NUM_NEURONS*OUT_W-1:0]  y_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted
);

  import neuron_pkg::*;

  localparam int unsigned XF_W = NUM_INPUTS * X_W;
  localparam int unsigned WF_W = NUM_INPUTS * W_W;
  localparam int unsigned YF_W = NUM_NEURONS * OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [XF_W-1:0]   x_reg, x_reg_n;
  logic [WF_W-1:0]   w_reg, w_reg_n;
  logic [B_W-1:0]    b_reg, b_reg_n;
  logic [YF_W-1:0]   y_n;
  logic              mac_valid;
  logic              aborted_n;

  assign wmem_addr    = idx;
  assign mac.in_valid = mac_valid;
  assign mac.bias     = b_reg;
  assign mac.x_flat   = x_reg;
  assign mac.w_flat   = w_reg;

  // State, datapath and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      x_reg     <= '0;
      w_reg     <= '0;
      b_reg     <= '0;
      y_flat    <= '0;
      wmem_rd   <= 1'b0;
      mac_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      x_reg     <= x_reg_n;
      w_reg     <= w_reg_n;
      b_reg     <= b_reg_n;
      y_flat    <= y_n;
      wmem_rd   <= (state_n == S_FETCH);
      mac_valid <= (state_n == S_ISSUE);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      aborted   <= aborted_n;
    end
  end

  // Next-state and datapath updates. The drain exit is judged on MAC status sampled
  // while already in DRAIN, so a job accepted on the abort edge is always waited out.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    x_reg_n   = x_reg;
    w_reg_n   = w_reg;
    b_reg_n   = b_reg;
    y_n       = y_flat;
    aborted_n = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          x_reg_n = x_flat;
          idx_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH:   state_n = S_WAIT_RD;
      S_WAIT_RD: begin
        w_reg_n = wmem_rdata_w;
        b_reg_n = wmem_rdata_b;
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (mac.in_ready) state_n = S_WAIT_MAC;
      end
      S_WAIT_MAC: begin
        if (mac.out_valid) begin
          for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
            if (idx == IDX_W'(n)) y_n[n*OUT_W +: OUT_W] = mac.out_data;
          end
          if (idx == LAST_IDX) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = S_FETCH;
          end
        end
      end
      S_DONE:    state_n = S_IDLE;
      S_DRAIN: begin
        if (aborted) begin
          state_n = S_IDLE;
        end else begin
          aborted_n = mac.in_ready && !mac.out_valid;
        end
      end
      default:   state_n = S_IDLE;
    endcase

    // Abort overrides everything in an active layer, including a result landing this cycle.
    if (abort && (state inside {S_FETCH, S_WAIT_RD, S_ISSUE, S_WAIT_MAC})) begin
      state_n = S_DRAIN;
      idx_n   = idx;
      y_n     = y_flat;
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench: behavioural weight memory and ReLU MAC around the layer sequencer.
module tb_neuron_layer_sched;

  localparam int unsigned NN = 4;
  localparam int unsigned NI = 8;
  localparam int unsigned IW = 2;
  localparam logic [63:0] YA  = {16'd62, 16'd44, 16'd26, 16'd8};
  localparam logic [63:0] X1  = {8{8'h01}};
  localparam logic [63:0] X2  = {8{8'h02}};
  localparam logic [63:0] W3  = {8{8'h03}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [NI*8-1:0]  x_flat;
  logic             wmem_rd;
  logic [IW-1:0]    wmem_addr;
  logic [NI*8-1:0]  wmem_rdata_w;
  logic [15:0]      wmem_rdata_b;
  logic [NN*16-1:0] y_flat;
  logic             busy, done, aborted;

  neuron_layer_sched_if #(.NUM_INPUTS(NI)) mac ();

  neuron_layer_sched #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_flat(x_flat),
    .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_rdata_w(wmem_rdata_w),
    .wmem_rdata_b(wmem_rdata_b), .mac(mac), .y_flat(y_flat),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Weight memory: neuron n weights all scale[n], bias bias_tab[n], one-cycle read latency.
  int scale [NN];
  int bias_tab [NN];
  logic [IW-1:0] addr_log [64];
  int addr_n = 0;
  always @(posedge clk) begin
    if (wmem_rd) begin
      for (int i = 0; i < int'(NI); i++) wmem_rdata_w[i*8 +: 8] <= 8'(scale[wmem_addr]);
      wmem_rdata_b <= 16'(bias_tab[wmem_addr]);
      addr_log[addr_n % 64] <= wmem_addr;
      addr_n <= addr_n + 1;
    end
  end

  // Serial MAC: accepts when idle, result strobe NI cycles after the accept edge.
  int mcnt;
  logic [15:0] mres;
  logic stall = 1'b0;
  logic force_ov = 1'b0;

  function automatic logic [15:0] mac_model(input logic [15:0] b, input logic [NI*8-1:0] xf,
                                            input logic [NI*8-1:0] wf);
    int acc;
    acc = int'($signed(b));
    for (int i = 0; i < int'(NI); i++)
      acc += int'($signed(xf[i*8 +: 8])) * int'($signed(wf[i*8 +: 8]));
    if (acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    return 16'(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      mres <= '0;
    end else if (mac.in_valid && mac.in_ready) begin
      mcnt <= int'(NI);
      mres <= mac_model(mac.bias, mac.x_flat, mac.w_flat);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mac.in_ready  = (mcnt == 0) && !stall;
  assign mac.out_valid = (mcnt == 1) || force_ov;
  assign mac.out_data  = force_ov ? 16'h7777 : mres;

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_layer();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (done) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic wait_aborted(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (aborted) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_busy"},    128'(busy), 128'(0));
    chk({pfx, "_done"},    128'(done), 128'(0));
    chk({pfx, "_aborted"}, 128'(aborted), 128'(0));
    chk({pfx, "_wmem_rd"}, 128'(wmem_rd), 128'(0));
    chk({pfx, "_addr"},    128'(wmem_addr), 128'(0));
    chk({pfx, "_valid"},   128'(mac.in_valid), 128'(0));
    chk({pfx, "_bias"},    128'(mac.bias), 128'(0));
    chk({pfx, "_x"},       128'(mac.x_flat), 128'(0));
    chk({pfx, "_w"},       128'(mac.w_flat), 128'(0));
    chk({pfx, "_y"},       128'(y_flat), 128'(0));
  endtask

  task automatic set_tables(input int sofs, input int bmul);
    for (int n = 0; n < int'(NN); n++) begin
      scale[n]    = n + sofs;
      bias_tab[n] = bmul * n;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    int base;
    x_flat = X1;
    set_tables(1, 10);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // Nominal layer: results, done cycle, address order.
    base = addr_n;
    start_layer();
    chk("t1_busy_c1", 128'(busy), 128'(1));
    chk("t1_rd_c1", 128'(wmem_rd), 128'(1));
    wait_done(100, at);
    chk("t1_done_cycle", 128'(at), 128'(45));
    chk("t1_busy_done", 128'(busy), 128'(1));
    chk("t1_y", 128'(y_flat), 128'(YA));
    chk("t1_nreads", 128'(addr_n - base), 128'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("t1_addr%0d", k), 128'(addr_log[(base + k) % 64]), 128'(k));
    step();
    chk("t1_busy_after", 128'(busy), 128'(0));
    chk("t1_done_after", 128'(done), 128'(0));

    // Start accepted the cycle after done; MAC stalls 5 cycles at neuron 2 issue.
    start_layer();
    chk("t2_rd_c1", 128'(wmem_rd), 128'(1));
    while (cyc < 25) step();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_valid_s%0d", k), 128'(mac.in_valid), 128'(1));
      chk($sformatf("t2_bias_s%0d", k), 128'(mac.bias), 128'(20));
      chk($sformatf("t2_w_s%0d", k), 128'(mac.w_flat), 128'(W3));
      chk($sformatf("t2_x_s%0d", k), 128'(mac.x_flat), 128'(X1));
      step();
    end
    stall = 1'b0;
    chk("t2_valid_release", 128'(mac.in_valid), 128'(1));
    wait_done(100, at);
    chk("t2_done_cycle", 128'(at), 128'(50));
    chk("t2_y", 128'(y_flat), 128'(YA));
    step();

    // Abort coincident with neuron 1 result: slot 1 keeps its old value.
    set_tables(2, 0);
    start_layer();
    while (cyc < 22) step();
    chk("t3_ov_seen", 128'(mac.out_valid), 128'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_busy_drain", 128'(busy), 128'(1));
    wait_aborted(30, at);
    chk("t3_aborted_cycle", 128'(at), 128'(24));
    chk("t3_busy_aborted", 128'(busy), 128'(1));
    chk("t3_y", 128'(y_flat), 128'({16'd62, 16'd44, 16'd26, 16'd16}));
    step();
    chk("t3_busy_after", 128'(busy), 128'(0));
    chk("t3_aborted_after", 128'(aborted), 128'(0));

    // Abort mid-job: drain outlasts the MAC, late result discarded.
    set_tables(3, 0);
    start_layer();
    while (cyc < 17) step();
    chk("t4_mac_busy", 128'(mac.in_ready), 128'(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_aborted(30, at);
    chk("t4_aborted_cycle", 128'(at), 128'(24));
    chk("t4_y", 128'(y_flat), 128'({16'd62, 16'd44, 16'd26, 16'd24}));
    step();
    chk("t4_busy_after", 128'(busy), 128'(0));

    // Start while busy, input vector change after latch, spurious result strobe in FETCH.
    set_tables(1, 10);
    base = done_cnt;
    start_layer();
    x_flat = X2;
    while (cyc < 5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 12) step();
    chk("t5_fetch_n1", 128'(wmem_rd), 128'(1));
    force_ov = 1'b1;
    step();
    force_ov = 1'b0;
    chk("t5_x_latched", 128'(mac.x_flat), 128'(X1));
    wait_done(100, at);
    chk("t5_done_cycle", 128'(at), 128'(45));
    repeat (3) step();
    chk("t5_done_count", 128'(done_cnt - base), 128'(1));
    chk("t5_y", 128'(y_flat), 128'(YA));
    chk("t5_idle", 128'(busy), 128'(0));
    x_flat = X1;

    // Asynchronous reset during neuron 2, then a clean layer.
    start_layer();
    while (cyc < 28) step();
    chk("t6_busy_pre", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_reset("t6");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    start_layer();
    wait_done(100, at);
    chk("t6_done_cycle", 128'(at), 128'(45));
    chk("t6_y", 128'(y_flat), 128'(YA));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
